// File: rtl/ode_pkg.sv
// Shared definitions for the ODE solver datapath: default widths, saturation
// limits and the state-stage FSM encoding.
package ode_pkg;

  localparam int DATA_WIDTH = 16;
  localparam int STEP_WIDTH = 16;

  localparam logic signed [DATA_WIDTH-1:0] SAT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [DATA_WIDTH-1:0] SAT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/ode_sat_select.sv
// Combinational clamp of a wrapped adder sum using the adder's overflow flag.
module ode_sat_select #(
  parameter int W = ode_pkg::DATA_WIDTH
) (
  input  logic signed [W-1:0] sum,
  input  logic                overflow,
  output logic signed [W-1:0] sat
);

  // A wrapped sum has the opposite sign of the true result, so a negative
  // looking sum with overflow means the true value ran off the positive end.
  function automatic logic signed [W-1:0] saturate(input logic signed [W-1:0] s,
                                                   input logic                ovf);
    if (!ovf)
      return s;
    return s[W-1] ? {1'b0, {(W-1){1'b1}}} : {1'b1, {(W-1){1'b0}}};
  endfunction

  assign sat = saturate(sum, overflow);

endmodule

// File: rtl/ode_step_accumulator.sv
// ODE state stage: saturates each accepted sum into x, counts steps and streams
// every new x through a one-entry output slot.
module ode_step_accumulator #(
  parameter int DATA_WIDTH = ode_pkg::DATA_WIDTH,
  parameter int STEP_WIDTH = ode_pkg::STEP_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic signed [DATA_WIDTH-1:0] init_value,
  input  logic        [STEP_WIDTH-1:0] num_steps,
  output logic signed [DATA_WIDTH-1:0] acc_value,
  input  logic                         res_valid,
  output logic                         res_ready,
  input  logic signed [DATA_WIDTH-1:0] result,
  input  logic                         overflow,
  output logic                         smp_valid,
  input  logic                         smp_ready,
  output logic signed [DATA_WIDTH-1:0] smp_data,
  output logic        [STEP_WIDTH-1:0] smp_index,
  output logic                         busy,
  output logic                         done,
  output logic                         sat_seen
);

  import ode_pkg::*;

  state_t                       state_q, state_d;
  logic signed [DATA_WIDTH-1:0] acc_q, smp_data_q, sat_v;
  logic        [STEP_WIDTH-1:0] cnt_q, target_q, smp_index_q;
  logic                         smp_valid_q, done_q, sat_seen_q;
  logic                         launch, accept, last_step, drain_exit;

  ode_sat_select #(.W(DATA_WIDTH)) u_sat (
    .sum      (result),
    .overflow (overflow),
    .sat      (sat_v)
  );

  // A result is admitted only when the slot is empty or is emptying this cycle,
  // which lets accept and drain overlap for one step per cycle.
  assign res_ready  = (state_q == RUN) && (!smp_valid_q || smp_ready);
  assign accept     = res_valid && res_ready;
  assign launch     = start && (state_q == IDLE || state_q == DONE);
  assign last_step  = (cnt_q == target_q - STEP_WIDTH'(1));
  assign drain_exit = (state_q == DRAIN) && (!smp_valid_q || smp_ready);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: if (start) state_d = (num_steps == '0) ? DONE : RUN;
      RUN:        if (accept && last_step) state_d = DRAIN;
      DRAIN:      if (drain_exit) state_d = DONE;
      default:    state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      smp_valid_q <= 1'b0;
      done_q      <= 1'b0;
      sat_seen_q  <= 1'b0;
      cnt_q       <= '0;
      target_q    <= '0;
    end else begin
      state_q <= state_d;
      if (launch) begin
        cnt_q      <= '0;
        target_q   <= num_steps;
        sat_seen_q <= 1'b0;
        done_q     <= (num_steps == '0);
      end else if (drain_exit) begin
        done_q <= 1'b1;
      end
      if (accept) begin
        cnt_q       <= cnt_q + STEP_WIDTH'(1);
        sat_seen_q  <= sat_seen_q | overflow;
        smp_valid_q <= 1'b1;
      end else if (smp_ready) begin
        smp_valid_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q       <= '0;
      smp_data_q  <= '0;
      smp_index_q <= '0;
    end else if (launch) begin
      acc_q <= init_value;
    end else if (accept) begin
      acc_q       <= sat_v;
      smp_data_q  <= sat_v;
      smp_index_q <= cnt_q;
    end
  end

  assign acc_value = acc_q;
  assign smp_valid = smp_valid_q;
  assign smp_data  = smp_data_q;
  assign smp_index = smp_index_q;
  assign busy      = (state_q == RUN) || (state_q == DRAIN);
  assign done      = done_q;
  assign sat_seen  = sat_seen_q;

endmodule
